core_mem_arbiter: RTL

Downstream neighbour of the pipeline core. It merges the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) onto one single-beat memory port (`mreq`/`mresp`). It grants one master at a time, latches the granted request, and holds it stable until the memory accepts it. It then routes the single `data_ok` response back to that master only.

---
 rtl/core_mem_arbiter_pkg.sv | 61 ++++++
 rtl/core_mem_arbiter_rr_grant.sv | 22 ++
 rtl/core_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// ============================================================================
// Module   : common (package)
// Purpose  : Bus structs, widths and arbiter state encoding shared by the
//            core memory arbiter and its round-robin grant helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                  valid;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                  data_ok;
        logic [MEM_DATA_W-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_DATA_W-1:0] data;
    } mbus_req_t;

    typedef struct packed {
        logic                  ready;
        logic                  data_ok;
        logic [MEM_DATA_W-1:0] data;
    } mbus_resp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/core_mem_arbiter_rr_grant.sv
// ============================================================================
// Module   : rr_grant
// Purpose  : Combinational two-way round-robin between fetch and data masters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant (
    input  logic i_ivalid,
    input  logic i_dvalid,
    input  logic i_last_d,
    output logic o_grant_i,
    output logic o_grant_d
);

    // On contention the master that was not served last wins.
    assign o_grant_d = i_dvalid & (~i_ivalid | ~i_last_d);
    assign o_grant_i = i_ivalid & (~i_dvalid |  i_last_d);

endmodule

`default_nettype wire

// File: rtl/core_mem_arbiter.sv
// ============================================================================
// Module   : core_mem_arbiter
// Purpose  : Merges the core's fetch and data buses onto one single-beat
//            memory port, one outstanding transaction at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mem_arbiter
    import common::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mbus_req_t  mreq,
    input  mbus_resp_t mresp
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              lat_is_write_q, lat_is_write_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [STRB_W-1:0] lat_strobe_q, lat_strobe_d;
    logic [DATA_W-1:0] lat_data_q, lat_data_d;

    logic w_grant_i;
    logic w_grant_d;
    logic w_resp_i;
    logic w_resp_d;

    rr_grant u_rr_grant (
        .i_ivalid  (ireq.valid),
        .i_dvalid  (dreq.valid),
        .i_last_d  (last_d_q),
        .o_grant_i (w_grant_i),
        .o_grant_d (w_grant_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b0;
            lat_is_write_q <= 1'b0;
            lat_addr_q     <= '0;
            lat_strobe_q   <= '0;
            lat_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            lat_is_write_q <= lat_is_write_d;
            lat_addr_q     <= lat_addr_d;
            lat_strobe_q   <= lat_strobe_d;
            lat_data_q     <= lat_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        lat_is_write_d = lat_is_write_q;
        lat_addr_d     = lat_addr_q;
        lat_strobe_d   = lat_strobe_q;
        lat_data_d     = lat_data_q;
        w_resp_i       = 1'b0;
        w_resp_d       = 1'b0;

        mreq          = '0;
        mreq.is_write = lat_is_write_q;
        mreq.addr     = lat_addr_q;
        mreq.strobe   = lat_strobe_q;
        mreq.data     = lat_data_q;

        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    lat_is_write_d = |dreq.strobe;
                    lat_addr_d     = dreq.addr;
                    lat_strobe_d   = dreq.strobe;
                    lat_data_d     = dreq.data;
                    last_d_d       = 1'b1;
                    state_d        = REQ_D;
                end else if (w_grant_i) begin
                    lat_is_write_d = 1'b0;
                    lat_addr_d     = ireq.addr;
                    lat_strobe_d   = '0;
                    lat_data_d     = '0;
                    last_d_d       = 1'b0;
                    state_d        = REQ_I;
                end
            end
            REQ_I, REQ_D: begin
                mreq.valid = 1'b1;
                // data_ok only counts once the request has been accepted.
                if (mresp.ready) begin
                    if (mresp.data_ok) begin
                        w_resp_i = (state_q == REQ_I);
                        w_resp_d = (state_q == REQ_D);
                        state_d  = IDLE;
                    end else begin
                        state_d = (state_q == REQ_D) ? WAIT_D : WAIT_I;
                    end
                end
            end
            WAIT_I, WAIT_D: begin
                if (mresp.data_ok) begin
                    w_resp_i = (state_q == WAIT_I);
                    w_resp_d = (state_q == WAIT_D);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A requester that withdrew its valid (e.g. flush) silently loses the response.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (w_resp_i && ireq.valid) begin
            iresp.data_ok = 1'b1;
            iresp.data    = lat_addr_q[2] ? mresp.data[63:32] : mresp.data[31:0];
        end
        if (w_resp_d && dreq.valid) begin
            dresp.data_ok = 1'b1;
            dresp.data    = mresp.data;
        end
    end

endmodule

`default_nettype wire
